// File: rtl/testbed_pkg.sv
// testbed_pkg: shared types and helpers for the testbed monitor.
//   state_e       - monitor FSM states
//   DEF_BEGIN_SYM - default arming symbol (value after byte swap)
//   DEF_END_SYM   - default end symbol (value after byte swap)
//   byte_swap     - reverses the byte order of the low nbytes bytes of a word
package testbed_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StDone
  } state_e;

  localparam logic [31:0] DEF_BEGIN_SYM = 32'h0000_0168;
  localparam logic [31:0] DEF_END_SYM   = 32'hFFFF_FD5D;

  // Widest data bus byte_swap can handle.
  localparam int unsigned SWAP_MAX_W = 256;

  // Callers pass a constant nbytes, so the loop unrolls to plain wiring.
  function automatic logic [SWAP_MAX_W-1:0] byte_swap(input logic [SWAP_MAX_W-1:0] d,
                                                     input int unsigned nbytes);
    logic [SWAP_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < nbytes; i++) begin
      r[i*8 +: 8] = d[(nbytes-1-i)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/testbed_answer_rom.sv
// testbed_answer_rom: constant answer table for FPGA builds, index -> expected value.
//   exp_idx  in  IDX_W   index of the requested answer
//   exp_data out DATA_W  answer for exp_idx (0 beyond DEPTH), combinational
// INIT packs entry i at bits [i*DATA_W +: DATA_W]; the build flow generates it from
// the answer hex file.
module testbed_answer_rom #(
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 13,
  parameter logic [DEPTH*DATA_W-1:0] INIT = '0
) (
  input  logic [IDX_W-1:0]  exp_idx,
  output logic [DATA_W-1:0] exp_data
);

  always_comb begin
    exp_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (exp_idx == IDX_W'(i)) begin
        exp_data = INIT[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/testbed_monitor.sv
// testbed_monitor: self-checking monitor on the data-memory write bus.
// Arms on BEGIN_SYM written to TEST_PORT, then compares each following test-port
// write against the expected value for exp_idx and reports the outcome.
//   clk, rst        clock and synchronous active-high reset
//   addr/data/wen   monitored bus (word address, write data, write enable)
//   exp_idx         index of the next expected value
//   exp_data        expected value for exp_idx, same cycle (ignored when USE_ROM)
//   error_num       mismatch count, 255 before arming
//   duration        cycles spent in CHECK
//   first_err_*     index, received and expected data of the first mismatch
//   timeout         CHECK ran out of cycles
//   early_end       END_SYM arrived before the last index
//   pass, finish    final verdict, finish held high once done
module testbed_monitor
  import testbed_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 30,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] TEST_PORT = ADDR_W'(10'h3FF),
  parameter logic [DATA_W-1:0] BEGIN_SYM = DATA_W'(DEF_BEGIN_SYM),
  parameter logic [DATA_W-1:0] END_SYM   = DATA_W'(DEF_END_SYM),
  parameter int unsigned       CHECK_NUM = 13,
  parameter int unsigned       IDX_W     = 10,
  parameter int unsigned       DUR_W     = 16,
  parameter logic [DUR_W-1:0]  TIMEOUT   = '1,
  parameter bit                BYTE_SWAP = 1'b1,
  parameter bit                USE_ROM   = 1'b0,
  parameter logic [CHECK_NUM*DATA_W-1:0] ROM_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  output logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  output logic [7:0]        error_num,
  output logic [DUR_W-1:0]  duration,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp,
  output logic              timeout,
  output logic              early_end,
  output logic              pass,
  output logic              finish
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_NUM - 1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;

  state_e            state_q, state_d;
  logic              wen_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        err_q, err_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [IDX_W-1:0]  fe_idx_q, fe_idx_d;
  logic [DATA_W-1:0] fe_got_q, fe_got_d;
  logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
  logic              timeout_q, timeout_d;
  logic              early_q, early_d;
  logic              pass_q, pass_d;
  logic              finish_q, finish_d;

  logic [DATA_W-1:0] dm;
  logic [DATA_W-1:0] exp_sel;
  logic              acc;
  logic              mismatch;
  logic              at_last;
  logic              is_early;

  if (USE_ROM) begin : g_rom
    testbed_answer_rom #(
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W),
      .DEPTH  (CHECK_NUM),
      .INIT   (ROM_INIT)
    ) u_rom (
      .exp_idx  (idx_q),
      .exp_data (exp_sel)
    );
  end else begin : g_ext
    assign exp_sel = exp_data;
  end

  assign dm = BYTE_SWAP ? DATA_W'(byte_swap(SWAP_MAX_W'(data), DATA_W / 8)) : data;

  // Rising edge of wen only, so a write held through a stall counts once.
  assign acc      = wen && !wen_q && (addr == TEST_PORT);
  assign mismatch = dm != exp_sel;
  assign at_last  = idx_q == LAST_IDX;
  assign is_early = (dm == END_SYM) && (idx_q < LAST_IDX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    dur_d     = dur_q;
    fe_idx_d  = fe_idx_q;
    fe_got_d  = fe_got_q;
    fe_exp_d  = fe_exp_q;
    timeout_d = timeout_q;
    early_d   = early_q;
    pass_d    = pass_q;
    finish_d  = finish_q;

    unique case (state_q)
      StIdle: begin
        if (acc && (dm == BEGIN_SYM)) begin
          state_d   = StCheck;
          idx_d     = '0;
          err_d     = '0;
          dur_d     = '0;
          fe_idx_d  = '0;
          fe_got_d  = '0;
          fe_exp_d  = '0;
          timeout_d = 1'b0;
          early_d   = 1'b0;
          pass_d    = 1'b0;
          finish_d  = 1'b0;
        end
      end
      StCheck: begin
        if (dur_q != DUR_MAX) begin
          dur_d = dur_q + 1'b1;
        end
        if (acc) begin
          idx_d = idx_q + 1'b1;
          if (mismatch) begin
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
            // err_q is 0 throughout CHECK until the first mismatch.
            if (err_q == 8'd0) begin
              fe_idx_d = idx_q;
              fe_got_d = dm;
              fe_exp_d = exp_sel;
            end
          end
        end
        // A terminating write beats a timeout landing in the same cycle.
        if (acc && (at_last || is_early)) begin
          state_d = StDone;
          early_d = is_early;
        end else if (dur_q == TIMEOUT - 1'b1) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
        if (state_d == StDone) begin
          finish_d = 1'b1;
          pass_d   = (err_d == 8'd0) && !timeout_d && !early_d;
        end
      end
      StDone: begin
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wen_q     <= 1'b0;
      idx_q     <= '0;
      err_q     <= 8'hFF;
      dur_q     <= '0;
      fe_idx_q  <= '0;
      fe_got_q  <= '0;
      fe_exp_q  <= '0;
      timeout_q <= 1'b0;
      early_q   <= 1'b0;
      pass_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen;
      idx_q     <= idx_d;
      err_q     <= err_d;
      dur_q     <= dur_d;
      fe_idx_q  <= fe_idx_d;
      fe_got_q  <= fe_got_d;
      fe_exp_q  <= fe_exp_d;
      timeout_q <= timeout_d;
      early_q   <= early_d;
      pass_q    <= pass_d;
      finish_q  <= finish_d;
    end
  end

  assign exp_idx       = idx_q;
  assign error_num     = err_q;
  assign duration      = dur_q;
  assign first_err_idx = fe_idx_q;
  assign first_err_got = fe_got_q;
  assign first_err_exp = fe_exp_q;
  assign timeout       = timeout_q;
  assign early_end     = early_q;
  assign pass          = pass_q;
  assign finish        = finish_q;

endmodule

// File: tb/tb_testbed_monitor.sv
// Scoreboard bench for testbed_monitor: each session's expected result is computed
// from the monitor's rules (write list with cycle offsets) and queued; a negedge
// monitor pops and compares when finish rises.
module tb_testbed_monitor;

  localparam int          TO        = 50;
  localparam int          CHECK_NUM = 13;
  localparam logic [29:0] TP        = 30'h3FF;
  localparam logic [31:0] BEG       = 32'h0000_0168;
  localparam logic [31:0] ENDS      = 32'hFFFF_FD5D;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic [9:0]  exp_idx;
  logic [31:0] exp_data;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic [9:0]  first_err_idx;
  logic [31:0] first_err_got;
  logic [31:0] first_err_exp;
  logic        timeout;
  logic        early_end;
  logic        pass;
  logic        finish;

  always #5 clk = ~clk;

  testbed_monitor #(
    .TIMEOUT (16'd50)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .data          (data),
    .wen           (wen),
    .exp_idx       (exp_idx),
    .exp_data      (exp_data),
    .error_num     (error_num),
    .duration      (duration),
    .first_err_idx (first_err_idx),
    .first_err_got (first_err_got),
    .first_err_exp (first_err_exp),
    .timeout       (timeout),
    .early_end     (early_end),
    .pass          (pass),
    .finish        (finish)
  );

  logic [31:0] exp_tab [1024];
  assign exp_data = exp_tab[exp_idx];

  typedef struct {
    bit          tp;
    logic [29:0] a;
    logic [31:0] dm;
    int          h;
    int          g;
  } ent_t;

  typedef struct {
    logic [7:0]  err;
    logic [15:0] dur;
    logic [9:0]  fidx;
    logic [9:0]  idx;
    logic [31:0] fgot;
    logic [31:0] fexp;
    bit          to;
    bit          ee;
    bit          ps;
  } res_t;

  ent_t ents[$];
  int   idx_after[$];
  res_t sb[$];
  int   hb, gb;
  int   checks = 0;
  int   errors = 0;
  bit   fin_seen = 1'b0;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit tp, input logic [31:0] dm, input int h, input int g);
    ent_t e;
    e.tp = tp;
    e.a  = tp ? TP : (30'($urandom) | 30'h1_0000);
    e.dm = dm;
    e.h  = h;
    e.g  = g;
    ents.push_back(e);
  endtask

  // Reference: walk accepted writes in order using their CHECK-cycle offsets.
  task automatic model();
    res_t r;
    int   t;
    int   k;
    bit   done;
    r.err = 0; r.dur = 0; r.fidx = 0; r.idx = 0; r.fgot = 0; r.fexp = 0;
    r.to = 0; r.ee = 0; r.ps = 0;
    idx_after.delete();
    done = 0;
    t = hb + gb - 1;
    foreach (ents[i]) begin
      if (ents[i].tp && !done && t <= TO - 1) begin
        k = int'(r.idx);
        if (ents[i].dm != exp_tab[k]) begin
          if (r.err == 0) begin
            r.fidx = 10'(k);
            r.fgot = ents[i].dm;
            r.fexp = exp_tab[k];
          end
          if (r.err != 8'hFF) r.err = r.err + 8'd1;
        end
        r.idx = r.idx + 10'd1;
        if (k == CHECK_NUM - 1) begin
          done  = 1;
          r.dur = 16'(t + 1);
        end else if (ents[i].dm == ENDS) begin
          done  = 1;
          r.ee  = 1;
          r.dur = 16'(t + 1);
        end
      end
      idx_after.push_back(int'(r.idx));
      t += ents[i].h + ents[i].g;
    end
    if (!done) begin
      r.to  = 1;
      r.dur = 16'(TO);
    end
    r.ps = (r.err == 0) && !r.to && !r.ee;
    sb.push_back(r);
  endtask

  task automatic do_write(input logic [29:0] a, input logic [31:0] dm, input int h, input int g);
    addr = a;
    data = swap32(dm);
    wen  = 1'b1;
    repeat (h) tick();
    wen  = 1'b0;
    addr = 30'($urandom);
    data = $urandom;
    repeat (g) tick();
  endtask

  task automatic reset_check();
    wen = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_error_num", 64'(error_num), 64'hFF);
    chk("rst_duration", 64'(duration), 0);
    chk("rst_exp_idx", 64'(exp_idx), 0);
    chk("rst_first_err", {first_err_got, 22'd0, first_err_idx}, 0);
    chk("rst_first_exp", 64'(first_err_exp), 0);
    chk("rst_flags", {timeout, early_end, pass, finish}, 0);
    rst = 1'b0;
    tick();
  endtask

  task automatic run_session();
    int n;
    model();
    // Noise in IDLE: wrong symbol on the port, right symbol on another address.
    do_write(TP, BEG ^ 32'h1, 1, 1);
    do_write(TP ^ 30'h1, BEG, 1, 1);
    chk("idle_ignored", {finish, 6'd0, exp_idx, error_num}, {1'b0, 6'd0, 10'd0, 8'hFF});
    do_write(TP, BEG, hb, gb);
    foreach (ents[i]) begin
      do_write(ents[i].a, ents[i].dm, ents[i].h, ents[i].g);
      chk("exp_idx_progress", 64'(exp_idx), 64'(idx_after[i]));
    end
    n = 0;
    while (!finish && n < TO + 20) begin
      tick();
      n++;
    end
    chk("finish_reached", 64'(finish), 1);
    tick();
    chk("sb_drained", 64'(sb.size()), 0);
    sb.delete();
    reset_check();
  endtask

  always @(negedge clk) begin : mon
    res_t e;
    if (!finish) begin
      fin_seen = 1'b0;
    end else if (!fin_seen) begin
      fin_seen = 1'b1;
      if (sb.size() == 0) begin
        chk("finish_unexpected", 64'(finish), 0);
      end else begin
        e = sb.pop_front();
        chk("error_num", 64'(error_num), 64'(e.err));
        chk("duration", 64'(duration), 64'(e.dur));
        chk("final_exp_idx", 64'(exp_idx), 64'(e.idx));
        chk("first_err_idx", 64'(first_err_idx), 64'(e.fidx));
        chk("first_err_got", 64'(first_err_got), 64'(e.fgot));
        chk("first_err_exp", 64'(first_err_exp), 64'(e.fexp));
        chk("timeout", 64'(timeout), 64'(e.to));
        chk("early_end", 64'(early_end), 64'(e.ee));
        chk("pass", 64'(pass), 64'(e.ps));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ans [13];
    logic [31:0] dm;
    int          nw, ntp, r;
    ans = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd1, 32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1,
            32'd0, ENDS};
    foreach (exp_tab[i]) exp_tab[i] = 32'd0;
    for (int i = 0; i < 13; i++) exp_tab[i] = ans[i];
    rst  = 1'b1;
    wen  = 1'b0;
    addr = '0;
    data = '0;
    tick();
    tick();
    reset_check();

    // All answers correct.
    hb = 1; gb = 1; ents.delete();
    for (int i = 0; i < 13; i++) add(1, ans[i], 1, 1);
    run_session();

    // Indices 3 and 7 wrong.
    ents.delete();
    for (int i = 0; i < 13; i++) add(1, (i == 3) ? 32'd5 : (i == 7) ? 32'd9 : ans[i], 1, 1);
    run_session();

    // First write held for four cycles.
    ents.delete();
    add(1, ans[0], 4, 1);
    for (int i = 1; i < 13; i++) add(1, ans[i], 1, 2);
    run_session();

    // END_SYM at index 5, trailing writes ignored.
    ents.delete();
    for (int i = 0; i < 5; i++) add(1, ans[i], 1, 1);
    add(1, ENDS, 1, 1);
    add(1, ans[6], 1, 1);
    add(1, ans[7], 1, 1);
    run_session();

    // Only three writes: timeout.
    ents.delete();
    for (int i = 0; i < 3; i++) add(1, ans[i], 1, 1);
    run_session();

    // Reset in the middle of CHECK.
    do_write(TP, BEG, 1, 1);
    do_write(TP, 32'd7, 1, 1);
    do_write(TP, ans[1], 1, 1);
    reset_check();
    do_write(TP, ans[0], 1, 1);
    chk("post_rst_idle", {finish, 6'd0, exp_idx, error_num}, {1'b0, 6'd0, 10'd0, 8'hFF});

    // Randomized sessions.
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < 13; i++) begin
        exp_tab[i] = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1) exp_tab[12] = ENDS;
      hb = $urandom_range(1, 2);
      gb = $urandom_range(1, 2);
      ents.delete();
      nw  = $urandom_range(1, 16);
      ntp = 0;
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          add(0, $urandom, $urandom_range(1, 3), $urandom_range(1, 3));
        end else begin
          r = $urandom_range(0, 9);
          if (r < 7) dm = exp_tab[ntp];
          else if (r < 9) dm = $urandom;
          else dm = ENDS;
          add(1, dm, $urandom_range(1, 3), $urandom_range(1, 3));
          ntp++;
        end
      end
      run_session();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/testbed_monitor.md
# testbed_monitor

Parametrised self-checking monitor on the CPU data-memory write bus, the next generation of the fixed 13-entry testbed checker. It arms on a begin symbol written to a test port, compares every subsequent test-port write against an external expected-value source, and reports error count, cycle duration, first-mismatch details, timeout and early-end status. It sits beside the L2/DRAM model in simulation benches and is synthesizable so it can also run on FPGA with a ROM answer source.

## Interface
- ADDR_W, 30: word-address width of the monitored bus.
- DATA_W, 32: data width; a multiple of 8.
- TEST_PORT, 30'h3FF: word address of the test port.
- BEGIN_SYM, 32'h00000168: arming symbol, after byte swap.
- END_SYM, 32'hFFFFFD5D: end symbol, after byte swap.
- CHECK_NUM, 13: number of compared writes, including the end symbol; 1..1023.
- IDX_W, 10: width of the expected-value index.
- DUR_W, 16: duration counter width.
- TIMEOUT, 16'hFFFF: CHECK-state cycle limit.
- BYTE_SWAP, 1: 1 = reverse byte order of data (little-endian bus); 0 = pass through.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  bus word address.
- data  in  DATA_W  bus write data.
- wen  in  1  bus write enable; may stay high for several cycles during a stall.
- exp_idx  out  IDX_W  index of the next expected value.
- exp_data  in  DATA_W  expected value for exp_idx, combinational, valid in the same cycle.
- error_num  out  8  mismatch count; 255 before arming.
- duration  out  DUR_W  cycles spent in CHECK.
- first_err_idx  out  IDX_W  index of the first mismatch.
- first_err_got  out  DATA_W  swapped data of the first mismatch.
- first_err_exp  out  DATA_W  expected data of the first mismatch.
- timeout  out  1  CHECK exceeded TIMEOUT.
- early_end  out  1  END_SYM received before index CHECK_NUM-1.
- pass  out  1  valid when finish=1: error_num==0 && !timeout && !early_end.
- finish  out  1  held high in DONE.

## Operation
- Swapped data dm = BYTE_SWAP ? byte-reversed data : data.
- Write acceptance: acc = wen && !wen_q && addr==TEST_PORT. wen_q is registered wen. A write held over stalled cycles counts once.
- FSM states IDLE, CHECK, DONE:
  - IDLE: acc && dm==BEGIN_SYM -> CHECK. error_num<=0, idx<=0, duration<=0, first-error and status flags cleared. Other accepted writes are ignored.
  - CHECK: duration increments every cycle, saturating. On acc, compare dm against exp_data (exp_idx=idx).
    - On mismatch, error_num increments, saturating at 255. If this is the first mismatch, capture idx, dm and exp_data.
    - idx increments on every acc.
    - An acc whose dm==END_SYM with idx<CHECK_NUM-1 is still compared, then sets early_end and moves to DONE.
    - An acc at idx==CHECK_NUM-1 moves to DONE.
    - If duration==TIMEOUT-1 with no terminating acc, set timeout and move to DONE. When both occur in the same cycle, the acc is processed and completion wins; timeout stays 0.
    - BEGIN_SYM written in CHECK is treated as ordinary data.
  - DONE: all outputs frozen, finish=1; only rst leaves.
- Non-test-port writes and reads never affect state.

## Timing
- Reset values: state IDLE, error_num 8'hFF, duration 0, exp_idx 0, first_err_* 0, timeout/early_end/pass/finish 0, wen_q 0.
- All outputs are registered. Compare results are visible one cycle after the acc edge.
- finish rises the cycle after the terminating acc or timeout cycle.
- exp_idx equals the internal idx register, so the external ROM has zero-cycle latency.
- rst asserted in any state returns the block to reset values on the next posedge, including mid-CHECK.
- Back-to-back writes need wen low for at least one cycle between them to be counted separately.

## Structure
- Package testbed_pkg: state enum (IDLE/CHECK/DONE), default BEGIN_SYM/END_SYM constants, byte_swap function.
- Sub-module testbed_answer_rom: parametrised exp_idx->exp_data ROM, initialised from a hex file, used by FPGA builds. Simulation benches may drive exp_data directly.

## Test plan
- Begin 0x168, then 13 correct writes ending 0xFFFFFD5D (answers 0,1,1,2,1,2,2,2,1,1,1,0,END) -> finish=1, error_num=0, pass=1, timeout=0.
- Same sequence with indices 3 and 7 wrong (got 5, 9) -> error_num=2, first_err_idx=3, first_err_got=5, first_err_exp=2, pass=0.
- wen held high 4 cycles on one write, then dropped -> idx advances by exactly 1.
- END_SYM written at idx 5 -> early_end=1, finish=1, error_num=1, pass=0.
- TIMEOUT=50, only 3 writes after begin -> timeout=1 at duration 50, finish=1, pass=0. Separately, rst mid-CHECK -> error_num=255, state IDLE.
